ram_arb: RTL and testbench
==========================

# ram_arb

Single-port synchronous RAM shared by NCH requester channels through a round-robin arbiter. It generalises the team's single-controller RAM interface (we/din/addr/dout) to a parametrised multi-channel front end with a req/gnt handshake, a tagged read-return pipeline and out-of-range address protection. It sits between several DMA/control engines and one on-chip memory array.

## Interface
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**AWID
- AWID, 8, address width
- DWID, 16, data width
- NCH, 4, number of requester channels, 2..16
- clk  input  1  rising-edge clock for all logic
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- req  input  NCH  per-channel access request
- we  input  NCH  per-channel write enable; 0 = read
- addr  input  NCH*AWID  channel i address at bits [i*AWID +: AWID]
- din  input  NCH*DWID  channel i write data at bits [i*DWID +: DWID]
- gnt  output  NCH  one-hot grant, combinational from req and the priority pointer
- rvalid  output  NCH  one-hot read-return strobe
- rdata  output  DWID  read data, shared; meaningful only while any rvalid bit is 1

## Operation
- Exactly one access per cycle. An access occurs on a rising edge where req[i] & gnt[i] = 1.
- Requester holds req, we, addr and din stable until it samples gnt[i]=1. req may be dropped without a grant; there is no penalty.
- Arbitration is round-robin. Pointer ptr (width clog2(NCH)) marks the highest-priority channel. The grant goes to the first requesting channel at or after ptr, scanning upward and wrapping modulo NCH.
- After a grant to channel i, ptr becomes (i+1) mod NCH. With no request, ptr holds its value.
- gnt = 0 when req = 0. gnt is never multi-hot. gnt[i] is never 1 unless req[i] = 1.
- Write: mem[addr] <= din on the grant edge.
- Read: the array is read on the grant edge. Return carries the granted channel index as a tag, so rvalid[tag] pulses for exactly one cycle.
- Out of range (addr >= DEPTH): a write is dropped and memory is unchanged. A read still returns, with rdata = 0 and the normal rvalid pulse.
- Read-after-write: a write to A at edge t followed by a read of A granted at edge t+1 returns the new data. Two accesses cannot collide in the same cycle.
- Reset: ptr = 0. The read pipeline is flushed, so reads in flight are dropped and never return. Memory contents are not reset.
- Reset outputs: gnt = 0 (req is ignored while rst_n = 0), rvalid = 0, rdata = 0.

## Timing
- gnt: combinational, in the same cycle as req.
- Read latency, measured from the grant edge to rvalid high: 1 cycle by default, 2 cycles with RAM_ARB_RDREG_EN.
- Back-to-back reads from any channels give rvalid on consecutive cycles, in grant order. Throughput is 1 access per cycle.
- rdata is held at its last value while rvalid = 0, apart from the reset value above.
- Only clk and rst_n are sampled; there are no other timing paths.

## Configuration
- RAM_ARB_RDREG_EN defined:
  - adds an output register stage on rdata and rvalid
  - read latency is 2
  - the out-of-range zeroing is applied before the register
  - reset clears both stages
- RAM_ARB_RDREG_EN undefined:
  - rdata comes directly from the array read register
  - read latency is 1

## Structure
- Package ram_arb_pkg:
  - function clog2_min1, returning at least 1, for the pointer and tag widths
  - function rr_pick(req, ptr), returning the one-hot grant
  - typedef for the tag width
- Sub-module rr_arbiter (parameter NCH):
  - holds ptr and its update logic
  - drives gnt and the granted index
- ram_arb top contains:
  - the array
  - address range check
  - channel demux of addr/din/we via the granted index
  - tag/valid pipeline
  - the optional output stage

## Test plan
- Reset, then req = 0 for 5 cycles -> gnt = 0, rvalid = 0, rdata = 0 throughout.
- Ch1 writes 0xBEEF to address 0x10, then ch2 reads 0x10 -> gnt[2] one cycle after gnt[1]; rvalid = 4'b0100 and rdata = 0xBEEF at latency 1 (2 with RAM_ARB_RDREG_EN).
- All 4 channels hold req continuously, starting from reset -> grant order 0,1,2,3,0,1,…; each channel gets exactly 1 grant in every 4 cycles.
- req = 4'b1010 with ptr = 2 -> gnt = 4'b1000, ptr becomes 0; the next cycle gives gnt = 4'b0010.
- DEPTH = 200: write 0x1234 to address 210, then read 210 -> memory unchanged, and rvalid is returned with rdata = 0. A read of address 199 returns the stored value.
- Grant a read, then assert rst_n = 0 on the next edge -> no rvalid ever appears for it; after reset, ptr = 0 and memory keeps 0xBEEF at address 0x10.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the multi-channel RAM arbiter (ram_arb).
// Optional feature macro used by the top: RAM_ARB_RDREG_EN.
package ram_arb_pkg;

  // Largest supported channel count; the helpers below are sized for it.
  localparam int MAX_NCH = 16;

  // Pointer/tag width, at least one bit even for tiny channel counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int TAG_W = clog2_min1(MAX_NCH);

  // Channel tag carried alongside a read through the return pipeline.
  typedef logic [TAG_W-1:0] tag_t;

  // Round-robin pick: first requester at or after ptr, wrapping modulo nch.
  // Bits at or above nch are never set.
  function automatic logic [MAX_NCH-1:0] rr_pick(input logic [MAX_NCH-1:0] req,
                                                 input logic [TAG_W-1:0]   ptr,
                                                 input int                 nch);
    logic [MAX_NCH-1:0] g;
    logic [TAG_W:0]     c;
    g = '0;
    for (int k = 0; k < MAX_NCH; k++) begin
      if (k < nch) begin
        c = {1'b0, ptr} + (TAG_W+1)'(k);
        if (c >= (TAG_W+1)'(nch)) c = c - (TAG_W+1)'(nch);
        if ((g == '0) && req[c[TAG_W-1:0]]) g[c[TAG_W-1:0]] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/ram_arb_arbiter.sv
// Round-robin arbiter for ram_arb: owns the priority pointer and produces a
// one-hot grant plus the granted channel index. Grants are suppressed while
// rst_n is low so requests are ignored during reset.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int NCH = 4,
  localparam int TW  = clog2_min1(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt,
  output logic [TW-1:0]  gnt_idx,
  output logic           gnt_any
);

  logic [TW-1:0]      ptr;
  logic [TW-1:0]      ptr_nxt;
  logic [MAX_NCH-1:0] pick;

  // Grant selection and index encode.
  always_comb begin
    pick    = rr_pick(MAX_NCH'(req), TAG_W'(ptr), NCH);
    gnt     = rst_n ? pick[NCH-1:0] : '0;
    gnt_any = rst_n & (|pick);
    gnt_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) gnt_idx = TW'(i);
    end
  end

  // Pointer moves just past the winner; holds when nobody is granted.
  always_comb begin
    ptr_nxt = ptr;
    if (gnt_any) begin
      ptr_nxt = (gnt_idx == TW'(NCH-1)) ? '0 : gnt_idx + TW'(1);
    end
  end

  // Pointer register with synchronous reset to channel 0.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

endmodule

// File: rtl/ram_arb.sv
// ram_arb: single-port synchronous RAM shared by NCH channels through a
// round-robin arbiter, with tagged read returns and out-of-range protection.
// Optional macro RAM_ARB_RDREG_EN adds an output register on rdata/rvalid
// (read latency 2 instead of 1).
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AWID  = 8,
  parameter int DWID  = 16,
  parameter int NCH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      req,
  input  logic [NCH-1:0]      we,
  input  logic [NCH*AWID-1:0] addr,
  input  logic [NCH*DWID-1:0] din,
  output logic [NCH-1:0]      gnt,
  output logic [NCH-1:0]      rvalid,
  output logic [DWID-1:0]     rdata
);

  localparam int TW = clog2_min1(NCH);
  localparam int MW = clog2_min1(DEPTH);

  logic [TW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [AWID-1:0] sel_addr;
  logic [DWID-1:0] sel_din;
  logic            sel_we;
  logic            in_range;
  logic            write_en;
  logic            read_en;
  logic [MW-1:0]   mem_idx;

  logic [DWID-1:0] mem [DEPTH];

  logic            rv1;
  tag_t            tag1;
  logic [DWID-1:0] rdata1;

  logic            out_v;
  tag_t            out_tag;
  logic [DWID-1:0] out_data;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Steer the winning channel's command onto the single RAM port.
  always_comb begin
    sel_addr = addr[gnt_idx*AWID +: AWID];
    sel_din  = din[gnt_idx*DWID +: DWID];
    sel_we   = we[gnt_idx];
    in_range = ({1'b0, sel_addr} < (AWID+1)'(DEPTH));
    mem_idx  = sel_addr[MW-1:0];
    write_en = gnt_any & sel_we & in_range;
    read_en  = gnt_any & ~sel_we;
  end

  // Memory array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (write_en) mem[mem_idx] <= sel_din;
  end

  // Array read register with tag; out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rv1    <= 1'b0;
      tag1   <= '0;
      rdata1 <= '0;
    end else begin
      rv1 <= read_en;
      if (read_en) begin
        tag1   <= tag_t'(gnt_idx);
        rdata1 <= in_range ? mem[mem_idx] : '0;
      end
    end
  end

`ifdef RAM_ARB_RDREG_EN
  logic            rv2;
  tag_t            tag2;
  logic [DWID-1:0] rdata2;

  // Extra output stage; rdata only advances when a read moves through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rv2    <= 1'b0;
      tag2   <= '0;
      rdata2 <= '0;
    end else begin
      rv2 <= rv1;
      if (rv1) begin
        tag2   <= tag1;
        rdata2 <= rdata1;
      end
    end
  end

  assign out_v    = rv2;
  assign out_tag  = tag2;
  assign out_data = rdata2;
`else
  assign out_v    = rv1;
  assign out_tag  = tag1;
  assign out_data = rdata1;
`endif

  // Decode the tag into the one-hot return strobe; outputs are quiet in reset
  // so a read in flight when reset arrives is never seen.
  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NCH; i++) begin
      rvalid[i] = rst_n & out_v & (out_tag == tag_t'(i));
    end
    rdata = rst_n ? out_data : '0;
  end

endmodule

// File: tb/tb_ram_arb.sv
module tb_ram_arb;

  localparam int DEPTH = 200;
  localparam int AWID  = 8;
  localparam int DWID  = 16;
  localparam int NCH   = 4;
`ifdef RAM_ARB_RDREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                clk;
  logic                rst_n;
  logic [NCH-1:0]      req;
  logic [NCH-1:0]      we;
  logic [NCH*AWID-1:0] addr;
  logic [NCH*DWID-1:0] din;
  logic [NCH-1:0]      gnt;
  logic [NCH-1:0]      rvalid;
  logic [DWID-1:0]     rdata;

  ram_arb #(.DEPTH(DEPTH), .AWID(AWID), .DWID(DWID), .NCH(NCH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              tag;
    logic [DWID-1:0] data;
    int              exp;
  } rd_t;

  rd_t             q[$];
  logic [DWID-1:0] mem_m [DEPTH];
  int              ptr_m;
  int              cyc;
  int              total;
  int              bad;
  logic [DWID-1:0] last_rd;

  initial begin
    cyc = 0; total = 0; bad = 0; ptr_m = 0; last_rd = '0;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // One request cycle: drive at negedge, check grant against the model,
  // then apply the access to the model (write to array, or queue the read).
  task automatic drive(input logic [NCH-1:0] r, input logic [NCH-1:0] w,
                       input logic [NCH*AWID-1:0] a, input logic [NCH*DWID-1:0] d);
    int g;
    int ag;
    @(negedge clk);
    req = r; we = w; addr = a; din = d;
    #1;
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (ptr_m + k) % NCH;
      if (g < 0 && r[c]) g = c;
    end
    chk("gnt", gnt, (g < 0) ? 0 : (1 << g));
    if (g >= 0) begin
      rd_t e;
      ptr_m = (g + 1) % NCH;
      ag = int'(a[g*AWID +: AWID]);
      if (w[g]) begin
        if (ag < DEPTH) mem_m[ag] = d[g*DWID +: DWID];
      end else begin
        e.tag  = g;
        e.data = (ag < DEPTH) ? mem_m[ag] : '0;
        e.exp  = cyc + LAT;
        q.push_back(e);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever a return strobe shows up.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_out", {rvalid, rdata}, '0);
      last_rd = '0;
    end else if (rvalid != '0) begin
      if (q.size() == 0) begin
        chk("unexpected_rvalid", rvalid, '0);
      end else begin
        rd_t e;
        e = q.pop_front();
        chk("rvalid", rvalid, 1 << e.tag);
        chk("rdata", rdata, e.data);
        chk("latency", cyc, e.exp);
      end
      last_rd = rdata;
    end else begin
      chk("rdata_hold", rdata, last_rd);
      if (q.size() > 0 && cyc >= q[0].exp) begin
        chk("rvalid_missing", rvalid, 1 << q[0].tag);
        void'(q.pop_front());
      end
    end
  end

  task automatic do_reset();
    req = '0; we = '0;
    rst_n = 1'b0;
    q.delete();
    ptr_m = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; we = '0; addr = '0; din = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: nothing granted, nothing returned, rdata zero.
    for (int k = 0; k < 5; k++) begin
      drive('0, '0, '0, '0);
      chk("idle_rvalid", rvalid, '0);
      chk("idle_rdata", rdata, '0);
    end

    // All channels requesting from reset: strict rotation 0,1,2,3,...
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 4'b1111, {4{8'(8 + k)}}, {4{16'(16'h1000 + k)}});
      chk("rr_order", gnt, 1 << (k % NCH));
    end

    // Fill the array so every in-range read has a known value.
    for (int i = 0; i < DEPTH; i++) begin
      drive(4'b0001, 4'b0001, AWID'(i), DWID'($urandom));
    end

    // Pointer lands on 2, then 1010 goes to ch3 and wraps to ch1.
    drive(4'b0010, 4'b0000, {4{8'h05}}, '0);
    drive(4'b1010, 4'b0000, {4{8'h06}}, '0);
    chk("ptr2_gnt", gnt, 4'b1000);
    drive(4'b1010, 4'b0000, {4{8'h07}}, '0);
    chk("wrap_gnt", gnt, 4'b0010);

    // Ch1 writes BEEF to 0x10, ch2 reads it back on the next cycle.
    drive(4'b0010, 4'b0010, {4{8'h10}}, {4{16'hBEEF}});
    chk("wr_gnt", gnt, 4'b0010);
    drive(4'b0100, 4'b0000, {4{8'h10}}, '0);
    chk("rd_gnt", gnt, 4'b0100);

    // Out-of-range write dropped, read returns zero; last word works.
    drive(4'b0001, 4'b0001, {4{8'd210}}, {4{16'h1234}});
    drive(4'b0001, 4'b0000, {4{8'd210}}, '0);
    drive(4'b0001, 4'b0001, {4{8'd199}}, {4{16'h5A5A}});
    drive(4'b0001, 4'b0000, {4{8'd199}}, '0);

    // A read granted right before reset must never return.
    drive(4'b1000, 4'b0000, {4{8'h10}}, '0);
    @(posedge clk);
    #1 do_reset();
    repeat (LAT + 2) drive('0, '0, '0, '0);
    // Pointer back at 0 (1010 -> ch1) and 0x10 still holds BEEF.
    drive(4'b1010, 4'b0000, {4{8'h10}}, '0);
    chk("post_reset_gnt", gnt, 4'b0010);

    // Randomised traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      logic [NCH*AWID-1:0] ra;
      logic [NCH*DWID-1:0] rd;
      for (int c = 0; c < NCH; c++) begin
        ra[c*AWID +: AWID] = AWID'($urandom_range(0, 255));
        rd[c*DWID +: DWID] = DWID'($urandom);
      end
      drive(NCH'($urandom_range(0, 15)), NCH'($urandom), ra, rd);
    end

    repeat (LAT + 3) drive('0, '0, '0, '0);
    chk("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
